// File: rtl/cpu_ctrl_seq_if.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_seq_if
//   Bundle between the control sequencer and its surroundings: the
//   instruction/immediate source (run, din) and the datapath control strobes
//   (ALU op, A/G strobes, register file selects, bus source selects), plus
//   the status outputs (done, illegal, instr_cnt).
//
//   Modports
//     master : the sequencer; samples run/din, drives every control/status line
//     slave  : instruction source + datapath; drives run/din, observes controls
//
//   Parameters
//     WORD   datapath width (din width)
//     NREG   number of general registers (one-hot select width)
//     CNT_W  retired-instruction counter width
// -----------------------------------------------------------------------------
interface cpu_ctrl_seq_if #(
  parameter int WORD  = 16,
  parameter int NREG  = 8,
  parameter int CNT_W = 16
);
  logic             run;
  logic [WORD-1:0]  din;
  logic [1:0]       alu_op;
  logic             a_in;
  logic             g_in;
  logic             g_out;
  logic             din_out;
  logic [NREG-1:0]  r_in;
  logic [NREG-1:0]  r_out;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  run, din,
    output alu_op, a_in, g_in, g_out, din_out, r_in, r_out, done, illegal, instr_cnt
  );

  modport slave (
    output run, din,
    input  alu_op, a_in, g_in, g_out, din_out, r_in, r_out, done, illegal, instr_cnt
  );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_seq
//   Control sequencer for a 16-bit register/ALU datapath. In T0 it fetches a
//   9-bit instruction (III XXX YYY) from din when run is high, then steps
//   T1..T3 issuing register-file, A/G, bus-source and ALU controls:
//     000 mv  Rx,Ry   T1: Ry -> bus -> Rx, done
//     001 mvi Rx,#D   T1: din -> bus -> Rx, done
//     010 add Rx,Ry   T1: Rx -> A;  T2: G <= A + Ry;  T3: G -> Rx, done
//     011 sub Rx,Ry   as add with G <= A - Ry
//     1xx reserved    see CTRL_ILLEGAL_EN below
//   All controls are a combinational decode of state + IR; only one bus
//   source is ever asserted in a cycle.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (state T0, IR 0, counter 0)
//     bus    cpu_ctrl_seq_if.master: run/din in; alu_op, a_in, g_in, g_out,
//            din_out, r_in, r_out, done, illegal, instr_cnt out
//
//   Build option
//     CTRL_ILLEGAL_EN  defined  : a 1xx opcode enters HALT (all outputs 0,
//                                 run ignored until reset) and sets a sticky
//                                 illegal flag; no done is produced.
//                      undefined: a 1xx opcode retires as a NOP in T1 and is
//                                 counted; illegal is tied 0.
// -----------------------------------------------------------------------------
module cpu_ctrl_seq #(
  parameter int WORD  = 16,
  parameter int NREG  = 8,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_ctrl_seq_if.master bus
);

  localparam int IR_W = 9;

  typedef enum logic [2:0] {
    T0, T1, T2, T3
`ifdef CTRL_ILLEGAL_EN
    , HALT
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALU_NOP = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10
  } alu_op_t;

  state_t           state, state_next;
  logic [IR_W-1:0]  ir;
  logic [CNT_W-1:0] instr_cnt;

  // Instruction fields.
  logic       op_rsvd;
  logic [1:0] op_low;
  logic [2:0] rx, ry;

  assign op_rsvd = ir[8];
  assign op_low  = ir[7:6];
  assign rx      = ir[5:3];
  assign ry      = ir[2:0];

  // Only din[8:0] carries the opcode; the upper bits are immediate-only.
  logic din_unused;
  assign din_unused = ^bus.din[WORD-1:IR_W];

  // Decoded controls.
  alu_op_t         alu_op;
  logic            a_in, g_in, g_out, din_out, done;
  logic [NREG-1:0] r_in, r_out;
`ifdef CTRL_ILLEGAL_EN
  logic            set_illegal;
  logic            illegal;
`endif

  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    onehot = NREG'(1) << idx;
  endfunction

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_next = state;
    alu_op     = ALU_NOP;
    a_in       = 1'b0;
    g_in       = 1'b0;
    g_out      = 1'b0;
    din_out    = 1'b0;
    done       = 1'b0;
    r_in       = '0;
    r_out      = '0;
`ifdef CTRL_ILLEGAL_EN
    set_illegal = 1'b0;
`endif

    case (state)
      T0: begin
        if (bus.run) state_next = T1;
      end

      T1: begin
        if (op_rsvd) begin
`ifdef CTRL_ILLEGAL_EN
          set_illegal = 1'b1;
          state_next  = HALT;
`else
          done       = 1'b1;
          state_next = T0;
`endif
        end else begin
          case (op_low)
            2'b00: begin            // mv
              r_out      = onehot(ry);
              r_in       = onehot(rx);
              done       = 1'b1;
              state_next = T0;
            end
            2'b01: begin            // mvi
              din_out    = 1'b1;
              r_in       = onehot(rx);
              done       = 1'b1;
              state_next = T0;
            end
            default: begin          // add / sub: first operand into A
              r_out      = onehot(rx);
              a_in       = 1'b1;
              state_next = T2;
            end
          endcase
        end
      end

      T2: begin
        r_out      = onehot(ry);
        g_in       = 1'b1;
        alu_op     = op_low[0] ? ALU_SUB : ALU_ADD;
        state_next = T3;
      end

      T3: begin
        g_out      = 1'b1;
        r_in       = onehot(rx);
        done       = 1'b1;
        state_next = T0;
      end

`ifdef CTRL_ILLEGAL_EN
      HALT: state_next = HALT;
`endif

      default: state_next = T0;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= T0;
      ir        <= '0;
      instr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == T0 && bus.run) ir <= bus.din[IR_W-1:0];
      if (done) instr_cnt <= instr_cnt + 1'b1;   // wraps naturally
    end
  end

`ifdef CTRL_ILLEGAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           illegal <= 1'b0;
    else if (set_illegal) illegal <= 1'b1;
  end
  assign bus.illegal = illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.alu_op    = alu_op;
  assign bus.a_in      = a_in;
  assign bus.g_in      = g_in;
  assign bus.g_out     = g_out;
  assign bus.din_out   = din_out;
  assign bus.r_in      = r_in;
  assign bus.r_out     = r_out;
  assign bus.done      = done;
  assign bus.instr_cnt = instr_cnt;

endmodule
